button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 116 +++++++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions a raw bouncing switch: synchronizes it, debounces with a four-state FSM,
// and produces a registered level, one-cycle RISE/FALL pulses and a wrapping press count.
module button_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       BTN,
  output logic       LEVEL,
  output logic       RISE,
  output logic       FALL,
  output logic [7:0] PRESSES
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_LOW_PEND,
    ST_HIGH,
    ST_HIGH_PEND
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [7:0]             r_presses;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], BTN};
    end
  end

  // Only the last synchronizer stage is allowed to reach the debounce logic.
  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_presses <= 8'd0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_LOW: begin
          if (w_s) begin
            r_state <= ST_LOW_PEND;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_LOW_PEND: begin
          if (!w_s) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_HIGH;
            r_cnt     <= '0;
            r_level   <= 1'b1;
            r_rise    <= 1'b1;
            r_presses <= r_presses + 8'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!w_s) begin
            r_state <= ST_HIGH_PEND;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_HIGH_PEND: begin
          if (w_s) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign LEVEL   = r_level;
  assign RISE    = r_rise;
  assign FALL    = r_fall;
  assign PRESSES = r_presses;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts every
// cycle's outputs, plus directed checks on latency, glitch rejection, wrap and reset.
module tb_button_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;

  logic       CLK;
  logic       CLR_N;
  logic       BTN;
  logic       LEVEL;
  logic       RISE;
  logic       FALL;
  logic [7:0] PRESSES;

  button_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) dut (
    .CLK    (CLK),
    .CLR_N  (CLR_N),
    .BTN    (BTN),
    .LEVEL  (LEVEL),
    .RISE   (RISE),
    .FALL   (FALL),
    .PRESSES(PRESSES)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] presses;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: level flips once S has disagreed with it for DB_CYCLES samples in a row.
  logic [SYNC_STAGES-1:0] m_sync;
  logic                   m_level;
  int                     m_run;
  logic                   m_rise;
  logic                   m_fall;
  logic [7:0]             m_presses;

  int n_rise;
  int n_fall;
  int t_idx;
  int first_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync    = '0;
    m_level   = 1'b0;
    m_run     = 0;
    m_rise    = 1'b0;
    m_fall    = 1'b0;
    m_presses = 8'd0;
  endtask

  task automatic clr_counts();
    n_rise     = 0;
    n_fall     = 0;
    t_idx      = 0;
    first_rise = 0;
  endtask

  task automatic tick(input logic b);
    logic s_old;
    exp_t e;
    BTN    = b;
    s_old  = m_sync[SYNC_STAGES-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s_old != m_level) begin
      m_run++;
      if (m_run == DB_CYCLES) begin
        m_level = s_old;
        m_run   = 0;
        if (m_level) begin
          m_rise    = 1'b1;
          m_presses = m_presses + 8'd1;
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_sync = {m_sync[SYNC_STAGES-2:0], b};
    sb_q.push_back('{level: m_level, rise: m_rise, fall: m_fall, presses: m_presses});

    @(posedge CLK);
    #1;
    t_idx++;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("level", LEVEL, e.level);
      chk("rise", RISE, e.rise);
      chk("fall", FALL, e.fall);
      chk("presses", PRESSES, e.presses);
    end
    chk("rise_fall_excl", RISE & FALL, 1'b0);
    if (RISE) begin
      n_rise++;
      if (first_rise == 0) first_rise = t_idx;
    end
    if (FALL) n_fall++;
  endtask

  // Asserts reset off-edge, checks the outputs clear without a clock, releases mid-cycle.
  task automatic do_reset(input string tag);
    CLR_N = 1'b0;
    #2;
    chk({tag, "_level"}, LEVEL, 1'b0);
    chk({tag, "_rise"}, RISE, 1'b0);
    chk({tag, "_fall"}, FALL, 1'b0);
    chk({tag, "_presses"}, PRESSES, 8'd0);
    model_reset();
    sb_q.delete();
    clr_counts();
    @(negedge CLK);
    CLR_N = 1'b1;
  endtask

  logic [8:0] bounce;

  initial begin
    CLR_N = 1'b0;
    BTN   = 1'b0;
    model_reset();
    clr_counts();
    #3;
    do_reset("rst0");

    // Clean press held: LEVEL/RISE appear SYNC_STAGES+DB_CYCLES edges after BTN is first sampled.
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk("press_latency", first_rise, SYNC_STAGES + DB_CYCLES);
    chk("press_nrise", n_rise, 1);
    chk("press_presses", PRESSES, 8'd1);
    chk("press_level", LEVEL, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("release_nfall", n_fall, 1);
    chk("release_level", LEVEL, 1'b0);

    // Short pulse below the debounce window is ignored.
    do_reset("rst1");
    for (int i = 0; i < 3; i++) tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("short_nrise", n_rise, 0);
    chk("short_level", LEVEL, 1'b0);
    chk("short_presses", PRESSES, 8'd0);

    // Bounce 1,0,1,1,0,1,1,1,1 then held.
    do_reset("rst2");
    bounce = 9'b1_1110_1101;
    for (int i = 0; i < 9; i++) tick(bounce[i]);
    for (int i = 0; i < 12; i++) tick(1'b1);
    chk("bounce_nrise", n_rise, 1);
    chk("bounce_nfall", n_fall, 0);
    chk("bounce_presses", PRESSES, 8'd1);

    // 256 clean presses wrap the counter back to zero.
    do_reset("rst3");
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 5; i++) tick(1'b1);
      for (int i = 0; i < 5; i++) tick(1'b0);
    end
    for (int i = 0; i < 6; i++) tick(1'b0);
    chk("wrap_nrise", n_rise, 256);
    chk("wrap_nfall", n_fall, 256);
    chk("wrap_presses", PRESSES, 8'd0);

    // Reset while HIGH_PEND with CNT=2: no residual FALL afterwards.
    do_reset("rst4");
    for (int i = 0; i < 10; i++) tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("hpend_level", LEVEL, 1'b1);
    chk("hpend_nfall", n_fall, 0);
    do_reset("rst_hpend");
    for (int i = 0; i < 12; i++) tick(1'b0);
    chk("post_rst_nfall", n_fall, 0);
    chk("post_rst_level", LEVEL, 1'b0);

    // Release reset with BTN held high: treated as a fresh press.
    BTN = 1'b1;
    do_reset("rst5");
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk("held_latency", first_rise, SYNC_STAGES + DB_CYCLES);
    chk("held_nrise", n_rise, 1);
    chk("held_presses", PRESSES, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
